// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access sizes, FSM states,
// wait-counter width and the load extension helper.
package dmem_pkg;

  localparam int WAIT_W = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Expects the selected lane already right-justified in v.
  function automatic logic [31:0] load_extend(input logic [31:0] v,
                                              input logic [1:0]  sz,
                                              input logic        uns);
    case (sz)
      SZ_BYTE: return {{24{~uns & v[7]}}, v[7:0]};
      SZ_HALF: return {{16{~uns & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_ctrl: store enables and replicated lane data,
// load lane extraction with sign/zero extension, and misalign/size errors.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_lane_wdata,
  output logic [31:0] o_rdata,
  output logic        o_fmt_err
);

  logic [31:0] w_shift;

  always_comb begin
    w_shift      = i_rword >> {i_addr_lo, 3'b000};
    o_be         = 4'b0000;
    o_lane_wdata = i_wdata;
    o_fmt_err    = 1'b0;
    case (i_size)
      SZ_BYTE: begin
        o_be         = 4'b0001 << i_addr_lo;
        o_lane_wdata = {4{i_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be         = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_lane_wdata = {2{i_wdata[15:0]}};
        o_fmt_err    = i_addr_lo[0];
      end
      SZ_WORD: begin
        o_be      = 4'b1111;
        o_fmt_err = |i_addr_lo;
      end
      default: o_fmt_err = 1'b1;
    endcase
    o_rdata = load_extend(w_shift, i_size, i_unsigned);
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory slave: one request at a time, programmable wait states, single-cycle
// response pulse. Define DMEM_TRACE_EN to print a simulation trace per response.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  o_dbg_state
);

  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_cnt;
  logic              r_we;
  logic              r_uns;
  logic [31:0]       r_addr;
  logic [1:0]        r_size;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_idle;
  logic              w_accept;
  logic              w_to_resp;
  logic              w_we;
  logic              w_uns;
  logic [31:0]       w_addr;
  logic [1:0]        w_size;
  logic [31:0]       w_off;
  logic              w_oor;
  logic [AW-1:0]     w_idx;
  logic [31:0]       w_rword;
  logic [3:0]        w_be;
  logic [31:0]       w_lane_wdata;
  logic [31:0]       w_rdata;
  logic              w_fmt_err;
  logic              w_err;

  // In IDLE the live request is decoded; afterwards the latched copy drives the
  // array read so the response cycle sees every store committed before it.
  assign w_idle    = (r_state == ST_IDLE);
  assign w_accept  = w_idle & req_valid;
  assign w_we      = w_idle ? req_we       : r_we;
  assign w_uns     = w_idle ? req_unsigned : r_uns;
  assign w_addr    = w_idle ? req_addr     : r_addr;
  assign w_size    = w_idle ? req_size     : r_size;
  assign w_off     = w_addr - BASE_ADDR;
  assign w_oor     = (w_off >= SPAN);
  assign w_idx     = w_off[AW+1:2];
  assign w_rword   = r_mem[w_idx];
  assign w_err     = w_oor | w_fmt_err;
  assign w_to_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                     ((r_state == ST_WAIT) && (r_cnt == '0));

  dmem_lane_align u_align (
    .i_addr_lo    (w_addr[1:0]),
    .i_size       (w_size),
    .i_unsigned   (w_uns),
    .i_wdata      (req_wdata),
    .i_rword      (w_rword),
    .o_be         (w_be),
    .o_lane_wdata (w_lane_wdata),
    .o_rdata      (w_rdata),
    .o_fmt_err    (w_fmt_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_we         <= 1'b0;
      r_uns        <= 1'b0;
      r_addr       <= '0;
      r_size       <= SZ_BYTE;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
    end else begin
      r_resp_valid <= w_to_resp;
      r_resp_err   <= w_to_resp & w_err;
      r_resp_rdata <= (w_to_resp && !w_err && !w_we) ? w_rdata : 32'h0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we   <= req_we;
            r_uns  <= req_unsigned;
            r_addr <= req_addr;
            r_size <= req_size;
            if (WAIT_CYCLES == 0) begin
              r_state <= ST_RESP;
            end else begin
              r_cnt   <= WAIT_W'(WAIT_CYCLES - 1);
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (r_cnt == '0) r_state <= ST_RESP;
          else             r_cnt   <= r_cnt - 1'b1;
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stores commit at the acceptance edge; array contents survive reset.
  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_lane_wdata[8*b +: 8];
      end
    end
  end

`ifdef DMEM_TRACE_EN
  logic [31:0] r_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_wdata <= '0;
    else if (w_accept) r_wdata <= req_wdata;
  end

  always_ff @(posedge clk) begin
    if (r_resp_valid) begin
      if (r_resp_err)
        $display("%04t:DMEM ERR addr 0x%08X size %0d", $time, r_addr, r_size);
      else
        $display("%04t:DMEM %s addr 0x%08X,content 0x%08X", $time,
                 r_we ? "write" : "read", r_addr, r_we ? r_wdata : r_resp_rdata);
    end
  end
`endif

  assign req_ready   = w_idle;
  assign resp_valid  = r_resp_valid;
  assign resp_rdata  = r_resp_rdata;
  assign resp_err    = r_resp_err;
  assign o_dbg_state = r_state;

endmodule
